trap_csr_unit: RTL and testbench

Machine-mode trap controller and CSR file that sits directly downstream of the history file. It takes the history file's kill and precise-exception report (`mepc`/`mcause`/`mtval`), commits them into the machine CSRs and redirects fetch to the trap vector. It also services CSR read/write from the execute stage and `mret` from writeback.

---
 rtl/trap_pkg.sv | 34 +++
 rtl/csr_regfile.sv | 90 +++++++++
 rtl/trap_csr_unit.sv | 114 +++++++++++
 tb/tb_trap_csr_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller and its CSR file.
package trap_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_t;

  function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_v, logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: csr_apply = wdata;
      CSR_OP_SET:   csr_apply = old_v | wdata;
      CSR_OP_CLEAR: csr_apply = old_v & ~wdata;
      default:      csr_apply = old_v;
    endcase
  endfunction
endpackage

// File: rtl/csr_regfile.sv
// Machine CSR storage: read mux, illegal-address decode, write-op arithmetic,
// plus the trap-entry and mret side effects commanded by the controller.
module csr_regfile
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC       = 32'h0000_2000,
  parameter logic        RESET_MSTATUS_MIE = 1'b0
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic [11:0] i_addr,
  input  csr_op_t     i_op,
  input  logic [31:0] i_wdata,
  input  logic        i_wr_en,
  input  logic        i_trap,
  input  logic [31:0] i_trap_mepc,
  input  logic [31:0] i_trap_mcause,
  input  logic [31:0] i_trap_mtval,
  input  logic        i_mret,
  output logic [31:0] o_rdata,
  output logic        o_illegal,
  output logic        o_mie,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);
  logic        r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [31:0] w_rdata, w_wval;
  logic        w_illegal;

  always_comb begin
    w_rdata   = '0;
    w_illegal = 1'b0;
    case (i_addr)
      CSR_MSTATUS: begin
        w_rdata[MIE_BIT]  = r_mie;
        w_rdata[MPIE_BIT] = r_mpie;
      end
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MTVAL:    w_rdata = r_mtval;
      default:      w_illegal = 1'b1;
    endcase
  end

  // Read-modify-write operates on the architecturally visible (masked) value.
  assign w_wval = csr_apply(i_op, w_rdata, i_wdata);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_mie      <= RESET_MSTATUS_MIE;
      r_mpie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (i_trap) begin
      r_mepc   <= {i_trap_mepc[31:2], 2'b00};
      r_mcause <= i_trap_mcause;
      r_mtval  <= i_trap_mtval;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (i_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (i_wr_en) begin
      case (i_addr)
        CSR_MSTATUS: begin
          r_mie  <= w_wval[MIE_BIT];
          r_mpie <= w_wval[MPIE_BIT];
        end
        CSR_MTVEC:    r_mtvec    <= {w_wval[31:2], 2'b00};
        CSR_MSCRATCH: r_mscratch <= w_wval;
        CSR_MEPC:     r_mepc     <= {w_wval[31:2], 2'b00};
        CSR_MCAUSE:   r_mcause   <= w_wval;
        CSR_MTVAL:    r_mtval    <= w_wval;
        default: ;
      endcase
    end
  end

  assign o_rdata   = w_rdata;
  assign o_illegal = w_illegal;
  assign o_mie     = r_mie;
  assign o_mtvec   = r_mtvec;
  assign o_mepc    = r_mepc;
endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap controller: drains on kill, commits the precise exception
// into the CSRs, redirects fetch to mtvec/mepc and arbitrates CSR writes.
module trap_csr_unit
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC       = 32'h0000_2000,
  parameter logic        RESET_MSTATUS_MIE = 1'b0
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        kill_instr_i,
  input  logic        exc_occured_i,
  input  logic [31:0] exc_mepc_i,
  input  logic [31:0] exc_mcause_i,
  input  logic [31:0] exc_mtval_i,
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        mret_i,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        mie_o
);
  trap_state_t r_state;
  logic        r_stall, r_redir_vld;
  logic [31:0] r_redir_pc;
  logic        w_trap, w_kill, w_mret, w_wr_en, w_dec_illegal;
  logic [31:0] w_mtvec, w_mepc;
  csr_op_t     w_op;

  assign w_op = csr_op_t'(csr_op_i);

  // Events are only honoured in the states that accept them; exc wins over kill wins over mret.
  assign w_trap  = exc_occured_i & (r_state != ST_REDIRECT);
  assign w_kill  = kill_instr_i & ~exc_occured_i & (r_state == ST_IDLE);
  assign w_mret  = mret_i & ~exc_occured_i & ~kill_instr_i & (r_state == ST_IDLE);
  assign w_wr_en = csr_req_i & (w_op != CSR_OP_READ) & ~w_dec_illegal & (r_state != ST_DRAIN)
                 & ~w_trap & ~w_kill & ~w_mret;

  csr_regfile #(
    .RESET_MTVEC       (RESET_MTVEC),
    .RESET_MSTATUS_MIE (RESET_MSTATUS_MIE)
  ) u_csr (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .i_addr        (csr_addr_i),
    .i_op          (w_op),
    .i_wdata       (csr_wdata_i),
    .i_wr_en       (w_wr_en),
    .i_trap        (w_trap),
    .i_trap_mepc   (exc_mepc_i),
    .i_trap_mcause (exc_mcause_i),
    .i_trap_mtval  (exc_mtval_i),
    .i_mret        (w_mret),
    .o_rdata       (csr_rdata_o),
    .o_illegal     (w_dec_illegal),
    .o_mie         (mie_o),
    .o_mtvec       (w_mtvec),
    .o_mepc        (w_mepc)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state     <= ST_IDLE;
      r_stall     <= 1'b0;
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_redir_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trap) begin
            r_state     <= ST_REDIRECT;
            r_stall     <= 1'b1;
            r_redir_vld <= 1'b1;
            r_redir_pc  <= w_mtvec;
          end else if (w_kill) begin
            r_state <= ST_DRAIN;
            r_stall <= 1'b1;
          end else if (w_mret) begin
            r_state     <= ST_REDIRECT;
            r_stall     <= 1'b1;
            r_redir_vld <= 1'b1;
            r_redir_pc  <= w_mepc;
          end
        end
        ST_DRAIN: begin
          if (w_trap) begin
            r_state     <= ST_REDIRECT;
            r_redir_vld <= 1'b1;
            r_redir_pc  <= w_mtvec;
          end
        end
        ST_REDIRECT: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign csr_illegal_o    = csr_req_i & w_dec_illegal;
  assign stall_o          = r_stall;
  assign redirect_valid_o = r_redir_vld;
  assign redirect_pc_o    = r_redir_pc;
endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: an abstract CSR/trap model checked every
// negedge, plus literal expectations pinning key results.
module tb_trap_csr_unit;
  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        kill_instr_i, exc_occured_i, csr_req_i, mret_i;
  logic [31:0] exc_mepc_i, exc_mcause_i, exc_mtval_i, csr_wdata_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        csr_illegal_o, stall_o, redirect_valid_o, mie_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  trap_csr_unit dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .kill_instr_i(kill_instr_i), .exc_occured_i(exc_occured_i),
    .exc_mepc_i(exc_mepc_i), .exc_mcause_i(exc_mcause_i), .exc_mtval_i(exc_mtval_i),
    .csr_req_i(csr_req_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .mret_i(mret_i), .stall_o(stall_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .mie_o(mie_o)
  );

  // Architectural model: CSR contents plus "busy" flags for drain and redirect.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_pc;
  bit          m_drain, m_redir, m_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_mstatus = 0; m_mtvec = 32'h2000; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_pc = 0; m_drain = 0; m_redir = 0; m_rv = 0;
  endtask

  task automatic m_csr_write();
    logic [31:0] v;
    if (csr_req_i && csr_op_i != 2'b00 && m_legal(csr_addr_i)) begin
      v = m_read(csr_addr_i);
      if (csr_op_i == 2'b01) v = csr_wdata_i;
      else if (csr_op_i == 2'b10) v = v | csr_wdata_i;
      else v = v & ~csr_wdata_i;
      case (csr_addr_i)
        12'h300: m_mstatus  = v & 32'h88;
        12'h305: m_mtvec    = v & ~32'h3;
        12'h340: m_mscratch = v;
        12'h341: m_mepc     = v & ~32'h3;
        12'h342: m_mcause   = v;
        default: m_mtval    = v;
      endcase
    end
  endtask

  task automatic m_edge();
    m_rv = 0;
    if (m_redir) begin
      m_redir = 0;
      m_csr_write();
    end else if (exc_occured_i) begin
      m_mepc = exc_mepc_i & ~32'h3; m_mcause = exc_mcause_i; m_mtval = exc_mtval_i;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      m_drain = 0; m_redir = 1; m_rv = 1; m_pc = m_mtvec;
    end else if (m_drain) begin
    end else if (kill_instr_i) begin
      m_drain = 1;
    end else if (mret_i) begin
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      m_redir = 1; m_rv = 1; m_pc = m_mepc;
    end else begin
      m_csr_write();
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall",    {31'b0, stall_o},          {31'b0, m_drain | m_redir});
      check("redir_v",  {31'b0, redirect_valid_o}, {31'b0, m_rv});
      check("redir_pc", redirect_pc_o,             m_pc);
      check("mie",      {31'b0, mie_o},            {31'b0, m_mstatus[3]});
      check("illegal",  {31'b0, csr_illegal_o},    {31'b0, csr_req_i & ~m_legal(csr_addr_i)});
      check("rdata",    csr_rdata_o,               m_read(csr_addr_i));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    if (chk_en) m_edge();
    #2;
  endtask

  task automatic clr();
    kill_instr_i = 0; exc_occured_i = 0; mret_i = 0; csr_req_i = 0;
    csr_op_i = 0; csr_wdata_i = 0;
    exc_mepc_i = 0; exc_mcause_i = 0; exc_mtval_i = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_req_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    tick();
    clr();
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr_i = a;
    #1;
    check(name, csr_rdata_o, exp);
  endtask

  initial begin
    int sc;
    rsn_i = 0; csr_addr_i = 12'h305; clr(); m_reset();
    #12;
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_rv", {31'b0, redirect_valid_o}, 32'h0);
    check("rst_pc", redirect_pc_o, 32'h0);
    peek("rst_mtvec", 12'h305, 32'h0000_2000);
    @(negedge clk_i) rsn_i = 1;
    tick();
    chk_en = 1;

    csr(2'b01, 12'h305, 32'h0000_4003);
    peek("mtvec_wr", 12'h305, 32'h0000_4000);
    csr(2'b10, 12'h300, 32'h8);
    check("mie_set", {31'b0, mie_o}, 32'h1);
    csr_req_i = 1; csr_addr_i = 12'h7C0; #1;
    check("ill_flag", {31'b0, csr_illegal_o}, 32'h1);
    check("ill_data", csr_rdata_o, 32'h0);
    tick(); clr();

    csr(2'b01, 12'h340, 32'hA5A5);
    csr(2'b10, 12'h340, 32'h0F00);
    csr(2'b11, 12'h340, 32'h0005);
    peek("mscratch_rmw", 12'h340, 32'h0000_AFA0);

    // kill, three drain cycles, then the precise exception
    sc = 0;
    kill_instr_i = 1; tick(); clr(); sc += int'(stall_o);
    for (int i = 0; i < 3; i++) begin tick(); sc += int'(stall_o); end
    exc_occured_i = 1; exc_mepc_i = 32'h100; exc_mcause_i = 2; exc_mtval_i = 32'hDEAD;
    tick(); clr(); sc += int'(stall_o);
    check("trap_rv", {31'b0, redirect_valid_o}, 32'h1);
    check("trap_pc", redirect_pc_o, 32'h0000_4000);
    for (int i = 0; i < 2; i++) begin tick(); sc += int'(stall_o); end
    check("stall_len", sc, 5);
    peek("mepc", 12'h341, 32'h100);
    peek("mcause", 12'h342, 32'h2);
    peek("mtval", 12'h343, 32'hDEAD);
    peek("mstatus_trap", 12'h300, 32'h80);

    // mret with a same-cycle CSR write that must be dropped
    mret_i = 1; csr_req_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'h55;
    tick(); clr();
    check("mret_rv", {31'b0, redirect_valid_o}, 32'h1);
    check("mret_pc", redirect_pc_o, 32'h100);
    tick();
    check("mret_rv_off", {31'b0, redirect_valid_o}, 32'h0);
    peek("mscratch_drop", 12'h340, 32'h0000_AFA0);
    peek("mstatus_mret", 12'h300, 32'h88);

    // kill together with exc: trap taken directly, misaligned mepc masked
    kill_instr_i = 1; exc_occured_i = 1; exc_mepc_i = 32'h203; exc_mcause_i = 5; exc_mtval_i = 32'h1;
    tick(); clr();
    check("kx_rv", {31'b0, redirect_valid_o}, 32'h1);
    check("kx_pc", redirect_pc_o, 32'h0000_4000);
    tick(); tick();
    peek("kx_mepc", 12'h341, 32'h200);
    csr(2'b10, 12'h300, 32'h8);

    // DRAIN ignores mret and writes, then reset mid-drain
    kill_instr_i = 1; tick(); clr();
    mret_i = 1; csr_req_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'h77;
    tick(); clr();
    check("drain_stall", {31'b0, stall_o}, 32'h1);
    check("drain_mie", {31'b0, mie_o}, 32'h1);
    peek("drain_wr_drop", 12'h340, 32'h0000_AFA0);
    chk_en = 0;
    rsn_i = 0; #1;
    check("arst_stall", {31'b0, stall_o}, 32'h0);
    check("arst_mie", {31'b0, mie_o}, 32'h0);
    peek("arst_mscratch", 12'h340, 32'h0);
    m_reset();
    @(negedge clk_i) rsn_i = 1;
    tick();
    chk_en = 1;
    sc = 0;
    for (int i = 0; i < 4; i++) begin tick(); sc += int'(redirect_valid_o) + int'(stall_o); end
    check("post_rst_quiet", sc, 0);
    peek("post_rst_mtvec", 12'h305, 32'h0000_2000);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
